// File: rtl/vscale_htif_tohost_monitor.sv
// vscale_htif_tohost_monitor
// Host-side HTIF PCR agent: polls the tohost CSR, clears it with a zero write
// once a nonzero value appears, and reports sticky pass / fail / timeout.
//
// state      | meaning
// -----------|------------------------------------------------------------
// S_IDLE     | interval counter running; next poll after POLL_INTERVAL cycles
// S_RD_REQ   | read request presented, waiting for req_ready
// S_RD_WAIT  | read accepted, waiting for the tohost value
// S_CLR_REQ  | zero-write request presented, waiting for req_ready
// S_CLR_WAIT | zero-write accepted, waiting for its (ignored) response
// S_DONE     | terminal; no further traffic on the PCR port

module vscale_htif_tohost_monitor #(
   parameter int                    PCR_WIDTH     = 64,
   parameter int                    ADDR_WIDTH    = 12,
   parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR   = 12'h780,
   parameter logic [PCR_WIDTH-1:0]  PASS_CODE     = PCR_WIDTH'(1),
   parameter int                    POLL_INTERVAL = 4,
   parameter int unsigned           MAX_CYCLES    = 2000
) (
   input  logic                  clk,
   input  logic                  reset,

   output logic                  htif_pcr_req_valid,
   input  logic                  htif_pcr_req_ready,
   output logic                  htif_pcr_req_rw,
   output logic [ADDR_WIDTH-1:0] htif_pcr_req_addr,
   output logic [PCR_WIDTH-1:0]  htif_pcr_req_data,

   input  logic                  htif_pcr_resp_valid,
   output logic                  htif_pcr_resp_ready,
   input  logic [PCR_WIDTH-1:0]  htif_pcr_resp_data,

   output logic                  done,
   output logic                  pass,
   output logic                  fail,
   output logic                  timeout,
   output logic [PCR_WIDTH-1:0]  fail_code,
   output logic [63:0]           cycle_count
);

   // An interval of 1 still needs a 1-bit counter.
   localparam int                CNT_W      = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
   localparam logic [CNT_W-1:0]  POLL_LAST  = CNT_W'(POLL_INTERVAL - 1);
   localparam logic [63:0]       MAX_CNT    = 64'(MAX_CYCLES);
   localparam bit                TIMEOUT_EN = (MAX_CYCLES != 0);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_RD_REQ   = 3'd1,
      S_RD_WAIT  = 3'd2,
      S_CLR_REQ  = 3'd3,
      S_CLR_WAIT = 3'd4,
      S_DONE     = 3'd5
   } state_e;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     poll_cnt_q, poll_cnt_d;
   logic                 pass_q, pass_d;
   logic                 fail_q, fail_d;
   logic                 timeout_q, timeout_d;
   logic [PCR_WIDTH-1:0] fail_code_q, fail_code_d;
   logic [63:0]          cycle_count_q, cycle_count_d;
   logic                 timeout_hit;
   logic                 resp_is_zero;
   logic                 resp_is_pass;

   // Free-running cycle counter, held at all-ones once it saturates.
   assign cycle_count_d = (&cycle_count_q) ? cycle_count_q : cycle_count_q + 64'd1;

   // The limit is judged against the count value this edge produces, so
   // timeout and cycle_count == MAX_CYCLES become visible together.
   assign timeout_hit  = TIMEOUT_EN && (cycle_count_d == MAX_CNT) && !timeout_q;

   assign resp_is_zero = (htif_pcr_resp_data == '0);
   assign resp_is_pass = (htif_pcr_resp_data == PASS_CODE);

   // Next-state and sticky-status logic.
   always_comb begin
      state_d     = state_q;
      poll_cnt_d  = poll_cnt_q;
      pass_d      = pass_q;
      fail_d      = fail_q;
      timeout_d   = timeout_q;
      fail_code_d = fail_code_q;

      case (state_q)
         S_IDLE: begin
            if (poll_cnt_q == POLL_LAST) begin
               poll_cnt_d = '0;
               state_d    = S_RD_REQ;
            end else begin
               poll_cnt_d = poll_cnt_q + 1'b1;
            end
         end
         S_RD_REQ: begin
            if (htif_pcr_req_ready) begin
               state_d = S_RD_WAIT;
            end
         end
         S_RD_WAIT: begin
            if (htif_pcr_resp_valid) begin
               if (resp_is_zero) begin
                  poll_cnt_d = '0;
                  state_d    = S_IDLE;
               end else begin
                  pass_d      = resp_is_pass;
                  fail_d      = !resp_is_pass;
                  fail_code_d = htif_pcr_resp_data >> 1;
                  state_d     = S_CLR_REQ;
               end
            end
         end
         S_CLR_REQ: begin
            if (htif_pcr_req_ready) begin
               state_d = S_CLR_WAIT;
            end
         end
         S_CLR_WAIT: begin
            if (htif_pcr_resp_valid) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_DONE;
         end
         default: begin
            state_d    = S_IDLE;
            poll_cnt_d = '0;
         end
      endcase

      // A capture on the same edge has already set pass_d/fail_d and wins.
      if (timeout_hit && !pass_d && !fail_d) begin
         timeout_d  = 1'b1;
         poll_cnt_d = '0;
         state_d    = S_DONE;
      end
   end

   // State and status registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         poll_cnt_q    <= '0;
         pass_q        <= 1'b0;
         fail_q        <= 1'b0;
         timeout_q     <= 1'b0;
         fail_code_q   <= '0;
         cycle_count_q <= '0;
      end else begin
         state_q       <= state_d;
         poll_cnt_q    <= poll_cnt_d;
         pass_q        <= pass_d;
         fail_q        <= fail_d;
         timeout_q     <= timeout_d;
         fail_code_q   <= fail_code_d;
         cycle_count_q <= cycle_count_d;
      end
   end

   // Request/response strobes depend on the registered state only, which also
   // keeps the request payload steady while the core stalls req_ready.
   assign htif_pcr_req_valid  = (state_q == S_RD_REQ) || (state_q == S_CLR_REQ);
   assign htif_pcr_req_rw     = (state_q == S_CLR_REQ);
   assign htif_pcr_req_addr   = TOHOST_ADDR;
   assign htif_pcr_req_data   = '0;
   assign htif_pcr_resp_ready = (state_q == S_RD_WAIT) || (state_q == S_CLR_WAIT);

   assign done        = pass_q | fail_q | timeout_q;
   assign pass        = pass_q;
   assign fail        = fail_q;
   assign timeout     = timeout_q;
   assign fail_code   = fail_code_q;
   assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_vscale_htif_tohost_monitor.sv
// Bench for vscale_htif_tohost_monitor: randomized core responder, transaction-level
// reference model, per-cycle compare plus hand-computed pins.
module tb_vscale_htif_tohost_monitor;

   localparam int          PW   = 64;
   localparam int          AW   = 12;
   localparam logic [11:0] TA   = 12'h780;
   localparam int          POLL = 4;
   localparam int          MAXC = 50;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          req_valid, req_ready, req_rw, resp_valid, resp_ready;
   logic [AW-1:0] req_addr;
   logic [PW-1:0] req_data, resp_data, fail_code;
   logic          done, pass, fail, timeout;
   logic [63:0]   cycle_count;

   always #5 clk = ~clk;

   vscale_htif_tohost_monitor #(
      .PCR_WIDTH(PW), .ADDR_WIDTH(AW), .TOHOST_ADDR(TA), .PASS_CODE(64'd1),
      .POLL_INTERVAL(POLL), .MAX_CYCLES(MAXC)
   ) dut (
      .clk(clk), .reset(reset),
      .htif_pcr_req_valid(req_valid), .htif_pcr_req_ready(req_ready),
      .htif_pcr_req_rw(req_rw), .htif_pcr_req_addr(req_addr), .htif_pcr_req_data(req_data),
      .htif_pcr_resp_valid(resp_valid), .htif_pcr_resp_ready(resp_ready),
      .htif_pcr_resp_data(resp_data),
      .done(done), .pass(pass), .fail(fail), .timeout(timeout),
      .fail_code(fail_code), .cycle_count(cycle_count)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: which transaction is outstanding and how far along it is.
   longint unsigned m_cyc, m_event_cyc;
   bit              m_pass, m_fail, m_tmo, m_end;
   bit              m_rd_pend, m_rd_acc, m_wr_pend, m_wr_acc;
   int              m_gap;
   logic [63:0]     m_code;

   // Stimulus knobs and observation counters.
   logic [63:0]     rd_q[$];
   int              ready_pct, resp_pct, hold_left;
   longint unsigned hold_until;
   bit              held_now;
   int              rd_cnt, wr_cnt, stable_cnt;

   function automatic bit e_req_valid();
      return (m_rd_pend && !m_rd_acc) || (m_wr_pend && !m_wr_acc);
   endfunction
   function automatic bit e_rw();
      return m_wr_pend && !m_wr_acc;
   endfunction
   function automatic bit e_resp_ready();
      return m_rd_acc || m_wr_acc;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_cyc = 0; m_event_cyc = 0;
      m_pass = 0; m_fail = 0; m_tmo = 0; m_end = 0;
      m_rd_pend = 0; m_rd_acc = 0; m_wr_pend = 0; m_wr_acc = 0;
      m_gap = 0; m_code = '0;
   endtask

   // One clock edge of the model, using the inputs the bench presented.
   task automatic model_step();
      longint unsigned nc;
      nc = (m_cyc == 64'hFFFF_FFFF_FFFF_FFFF) ? m_cyc : m_cyc + 1;
      if (!m_end) begin
         if (m_rd_acc) begin
            if (resp_valid) begin
               m_rd_pend = 0; m_rd_acc = 0;
               if (rd_q.size() > 0) void'(rd_q.pop_front());
               if (resp_data != 0) begin
                  if (resp_data == 64'd1) m_pass = 1; else m_fail = 1;
                  m_code      = resp_data >> 1;
                  m_wr_pend   = 1;
                  m_event_cyc = nc;
               end
            end
         end else if (m_rd_pend) begin
            if (req_ready) m_rd_acc = 1;
         end else if (m_wr_acc) begin
            if (resp_valid) begin m_wr_pend = 0; m_wr_acc = 0; m_end = 1; end
         end else if (m_wr_pend) begin
            if (req_ready) m_wr_acc = 1;
         end else begin
            m_gap++;
            if (m_gap == POLL) begin m_rd_pend = 1; m_gap = 0; end
         end
      end
      if (nc == 64'(MAXC) && !m_pass && !m_fail && !m_tmo) begin
         m_tmo = 1; m_end = 1; m_event_cyc = nc;
         m_rd_pend = 0; m_rd_acc = 0; m_wr_pend = 0; m_wr_acc = 0;
      end
      m_cyc = nc;
   endtask

   task automatic drive();
      held_now = 0;
      if (e_req_valid() && !e_rw() && hold_left > 0) begin
         req_ready = 1'b0; hold_left--; held_now = 1;
      end else begin
         req_ready = (int'($urandom_range(0, 99)) < ready_pct);
      end
      if (m_rd_acc || m_wr_acc) begin
         if (m_rd_acc && m_cyc < hold_until) resp_valid = 1'b0;
         else resp_valid = (int'($urandom_range(0, 99)) < resp_pct);
         if (m_rd_acc) resp_data = (rd_q.size() > 0) ? rd_q[0] : 64'd0;
         else resp_data = {$urandom, $urandom};
      end else begin
         // Responses nobody asked for must be ignored.
         resp_valid = ($urandom_range(0, 3) == 0);
         resp_data  = {$urandom, $urandom} | 64'd1;
      end
   endtask

   task automatic compare_all();
      check("req_valid",   64'(req_valid),   64'(e_req_valid()));
      check("req_rw",      64'(req_rw),      64'(e_rw()));
      check("req_addr",    64'(req_addr),    64'(TA));
      check("req_data",    req_data,         64'd0);
      check("resp_ready",  64'(resp_ready),  64'(e_resp_ready()));
      check("done",        64'(done),        64'(m_pass || m_fail || m_tmo));
      check("pass",        64'(pass),        64'(m_pass));
      check("fail",        64'(fail),        64'(m_fail));
      check("timeout",     64'(timeout),     64'(m_tmo));
      check("fail_code",   fail_code,        m_code);
      check("cycle_count", cycle_count,      m_cyc);
      if (!reset && req_valid === 1'b1 && req_ready === 1'b1) begin
         if (req_rw) wr_cnt++; else rd_cnt++;
      end
      if (held_now && req_valid === 1'b1 && req_rw === 1'b0 && req_addr === TA) stable_cnt++;
   endtask

   task automatic cycle();
      @(posedge clk);
      if (!reset) model_step();
      #1;
      drive();
      @(negedge clk);
      compare_all();
   endtask

   task automatic do_reset();
      #1 reset = 1'b1;
      model_reset();
      rd_cnt = 0; wr_cnt = 0; stable_cnt = 0;
      cycle(); cycle();
      #1 reset = 1'b0;
   endtask

   task automatic first_poll_check();
      repeat (3) cycle();
      check("first_poll_early", 64'(req_valid), 64'd0);
      cycle();
      check("first_poll",       64'(req_valid), 64'd1);
      check("first_poll_cyc",   cycle_count,    64'd4);
   endtask

   task automatic run_until_end(input int limit);
      int n = 0;
      while (!m_end && n < limit) begin cycle(); n++; end
      if (!m_end) begin
         total++; bad++;
         $display("FAIL bound: no completion within %0d cycles", limit);
      end
      repeat (4) cycle();
   endtask

   task automatic setup(input int rp, input int sp, input int hl, input longint unsigned hu);
      ready_pct = rp; resp_pct = sp; hold_left = hl; hold_until = hu;
   endtask

   initial begin
      req_ready = 1'b0; resp_valid = 1'b0; resp_data = '0; held_now = 0;
      model_reset();
      setup(100, 100, 0, 0);

      // Reset state before any clock.
      #2;
      check("rst_req_valid", 64'(req_valid), 64'd0);
      check("rst_done",      64'(done),      64'd0);
      check("rst_count",     cycle_count,    64'd0);

      // Three zero polls then PASS_CODE.
      rd_q = '{64'd0, 64'd0, 64'd0, 64'd1};
      do_reset();
      first_poll_check();
      run_until_end(200);
      check("pass_flag",    64'(pass),   64'd1);
      check("pass_done",    64'(done),   64'd1);
      check("pass_nofail",  64'(fail),   64'd0);
      check("pass_reads",   64'(rd_cnt), 64'd4);
      check("pass_writes",  64'(wr_cnt), 64'd1);
      check("pass_at_cyc",  m_event_cyc, 64'd24);

      // Fail code 0x90 with a moderately stalling core.
      setup(80, 60, 0, 0);
      rd_q = '{64'h90};
      do_reset();
      run_until_end(200);
      check("fail_flag",   64'(fail),   64'd1);
      check("fail_nopass", 64'(pass),   64'd0);
      check("fail_code",   fail_code,   64'd72);
      check("fail_writes", 64'(wr_cnt), 64'd1);

      // req_ready held low for 10 cycles on the first read.
      setup(100, 100, 10, 0);
      rd_q = '{64'h2A};
      do_reset();
      run_until_end(200);
      check("stall_stable", 64'(stable_cnt), 64'd10);
      check("stall_reads",  64'(rd_cnt),     64'd1);
      check("stall_writes", 64'(wr_cnt),     64'd1);
      check("stall_code",   fail_code,       64'd21);

      // tohost stays zero: timeout at MAX_CYCLES.
      setup(50, 50, 0, 0);
      rd_q = {};
      do_reset();
      run_until_end(200);
      check("tmo_at_cyc",    m_event_cyc,     64'd50);
      check("tmo_flag",      64'(timeout),    64'd1);
      check("tmo_done",      64'(done),       64'd1);
      check("tmo_req_valid", 64'(req_valid),  64'd0);
      check("tmo_resp_rdy",  64'(resp_ready), 64'd0);

      // Nonzero response consumed on the edge the count reaches MAX_CYCLES.
      setup(100, 100, 0, 64'(MAXC - 1));
      rd_q = '{64'h90};
      do_reset();
      run_until_end(200);
      check("edge_at_cyc",  m_event_cyc,  64'd50);
      check("edge_fail",    64'(fail),    64'd1);
      check("edge_timeout", 64'(timeout), 64'd0);
      check("edge_code",    fail_code,    64'd72);

      // Reset pulsed while the clear-write is outstanding.
      setup(100, 0, 0, 0);
      rd_q = '{64'd1};
      resp_pct = 100;
      do_reset();
      begin
         int n = 0;
         while (!m_wr_acc && n < 100) begin cycle(); n++; end
         if (!m_wr_acc) begin
            total++; bad++;
            $display("FAIL bound: clear-write never accepted");
         end
      end
      #1 reset = 1'b1;
      model_reset();
      #1;
      check("mid_rst_req_valid",  64'(req_valid),  64'd0);
      check("mid_rst_resp_ready", 64'(resp_ready), 64'd0);
      check("mid_rst_pass",       64'(pass),       64'd0);
      check("mid_rst_done",       64'(done),       64'd0);
      check("mid_rst_count",      cycle_count,     64'd0);
      rd_cnt = 0; wr_cnt = 0; stable_cnt = 0;
      rd_q = '{64'h90};
      cycle(); cycle();
      #1 reset = 1'b0;
      first_poll_check();
      run_until_end(200);
      check("post_rst_fail", 64'(fail), 64'd1);
      check("post_rst_code", fail_code, 64'd72);

      // Random soak against the model.
      for (int s = 0; s < 10; s++) begin
         int nz;
         logic [63:0] last;
         setup(int'($urandom_range(30, 100)), int'($urandom_range(30, 100)),
               int'($urandom_range(0, 3)), 0);
         rd_q = {};
         nz = int'($urandom_range(0, 3));
         for (int k = 0; k < nz; k++) rd_q.push_back(64'd0);
         case ($urandom_range(0, 2))
            0:       last = 64'd1;
            1:       last = {$urandom, $urandom} | 64'd2;
            default: last = 64'd0;
         endcase
         rd_q.push_back(last);
         do_reset();
         run_until_end(300);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vscale_htif_tohost_monitor.md
# vscale_htif_tohost_monitor

Synthesizable host-side agent for the vscale HTIF PCR port, sitting directly upstream of `vscale_top` on its `htif_pcr_req_*` / `htif_pcr_resp_*` channels. It periodically reads the `tohost` CSR and, when the value is nonzero, latches it and writes zero back to clear it. It then reports pass, fail (with test number) or timeout as sticky status outputs, so test benches and FPGA wrappers can end simulation or light an LED without behavioural polling code.

## Interface
- `PCR_WIDTH`, 64: HTIF PCR data width.
- `ADDR_WIDTH`, 12: CSR address width.
- `TOHOST_ADDR`, 12'h780: CSR address polled (`tohost`).
- `PASS_CODE`, 1: `tohost` value meaning pass.
- `POLL_INTERVAL`, 4: idle cycles between polls; legal range ≥1.
- `MAX_CYCLES`, 2000: timeout limit in cycles after reset; 0 disables the timeout.

Ports:
- `clk`, in, 1: clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous reset, active-high.
- `htif_pcr_req_valid`, out, 1: request valid.
- `htif_pcr_req_ready`, in, 1: request accepted by the core.
- `htif_pcr_req_rw`, out, 1: 0 = read, 1 = write.
- `htif_pcr_req_addr`, out, ADDR_WIDTH: always `TOHOST_ADDR`.
- `htif_pcr_req_data`, out, PCR_WIDTH: write data; always 0.
- `htif_pcr_resp_valid`, in, 1: response valid.
- `htif_pcr_resp_ready`, out, 1: response accepted.
- `htif_pcr_resp_data`, in, PCR_WIDTH: response data.
- `done`, out, 1: sticky; pass, fail or timeout has occurred.
- `pass`, out, 1: sticky; captured `tohost` == `PASS_CODE`.
- `fail`, out, 1: sticky; captured `tohost` nonzero and != `PASS_CODE`.
- `timeout`, out, 1: sticky; `MAX_CYCLES` reached before any nonzero `tohost` was captured.
- `fail_code`, out, PCR_WIDTH: captured value >> 1 (logical shift, zero-filled MSB); valid when `fail`.
- `cycle_count`, out, 64: cycles elapsed since reset deassertion; saturates at all-ones.

## Operation
- States:
  - IDLE: interval counter runs; after `POLL_INTERVAL` cycles → RD_REQ.
  - RD_REQ: `req_valid`=1, `rw`=0; on `req_valid & req_ready` → RD_WAIT.
  - RD_WAIT: `resp_ready`=1; on `resp_valid`, capture data. Zero → IDLE with the interval counter cleared. Nonzero → set `pass` or `fail`, load `fail_code`, → CLR_REQ.
  - CLR_REQ: `req_valid`=1, `rw`=1, `req_data`=0; on handshake → CLR_WAIT.
  - CLR_WAIT: `resp_ready`=1; on `resp_valid` → DONE (response data ignored).
  - DONE: terminal; no requests issued; `resp_ready`=0.
- `done` asserts on the same edge that sets `pass`, `fail` or `timeout`. The clear-write sequence continues after `done` rises.
- Timeout:
  - `cycle_count` == `MAX_CYCLES` (nonzero) while neither `pass` nor `fail` is set: set `timeout`, force DONE.
  - An outstanding request is abandoned and `req_valid` drops.
- Only one request is outstanding at a time; a new request is never issued before the previous response is consumed.
- `pass`, `fail` and `timeout` are mutually exclusive.

## Timing
- Reset values: state = IDLE, every output 0 (`req_addr` = `TOHOST_ADDR` constant), all counters 0.
- `req_valid`, `rw`, `req_addr`, `req_data` and `resp_ready` are decoded from registered state only; none combinationally depends on `*_ready` or `*_valid` inputs.
- Request payload is held stable while `req_valid`=1 and `req_ready`=0.
- Handshake fires in a cycle where both valid and ready are high; the state changes at that edge.
- A response arriving the same cycle as request acceptance is ignored, because `resp_ready`=0 in the *_REQ states.
- First poll: `req_valid` rises `POLL_INTERVAL` cycles after reset deasserts.
- Capture to status: `pass`/`fail`/`done` are visible the cycle after the accepted response.
- Timeout and nonzero capture on the same edge: the capture wins and `timeout` stays 0.
- `reset` asserted mid-transaction returns the block to IDLE immediately and clears all sticky flags; no clear-write is completed.

## Test plan
- Responder returns 0 three times, then 1 → `pass`=1, `done`=1, one write with `rw`=1, `req_data`=0 issued, no further requests.
- Responder returns 0x90 (144) → `fail`=1, `fail_code`=72, clear-write issued, `pass`=0.
- `req_ready` held low 10 cycles in RD_REQ → `req_valid`/`addr`/`rw` stable all 10 cycles, exactly one handshake.
- Responder always returns 0, `MAX_CYCLES`=50 → `timeout` and `done` set when `cycle_count`=50, `req_valid`=0 afterwards.
- Nonzero response accepted on the cycle `cycle_count` reaches `MAX_CYCLES` → `fail` or `pass` set, `timeout`=0.
- `reset` pulsed during CLR_WAIT (between clock edges) → all outputs 0 immediately; polling restarts `POLL_INTERVAL` cycles after release.
